// File: rtl/switch_input_pkg.sv
// Shared sizing defaults and autorepeat timing for the switch input port.
// Latency/backpressure: none (constants and a pointer-width helper only).
package switch_input_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  localparam logic [15:0] REPEAT_DELAY = 16'd50000;
  localparam logic [15:0] REPEAT_RATE  = 16'd10000;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: rdata is the head straight from storage; writes land one clock after push.
// Push when full is ignored unless a pop happens the same cycle; pop when empty is ignored.
module sync_fifo
  import switch_input_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic [ptr_w(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/switch_input_port.sv
// IN-instruction responder: synchronized enter press captures switches into a FIFO; DB_out rise to data_valid is SYNC_STAGES+1 clocks.
// Stalls the CPU via hlt_req while empty; drops presses when full (sticky overflow). SWITCH_INPUT_PORT_AUTOREPEAT_EN adds hold-to-repeat.
module switch_input_port
  import switch_input_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     switches,
  input  logic                  DB_out,
  input  logic                  cu_inSignal,
  output logic [DATA_W-1:0]     in_data,
  output logic                  data_valid,
  output logic                  hlt_req,
  output logic                  full,
  output logic                  overflow,
  output logic [ptr_w(DEPTH):0] count
);
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [DATA_W-1:0]      sw_sync_q [SYNC_STAGES];
  logic                   btn_sync;
  logic                   btn_prev;
  logic                   btn_rise;
  logic                   repeat_push;
  logic                   push;
  logic                   pop;
  logic                   empty;

  assign btn_sync = btn_sync_q[SYNC_STAGES-1];
  assign btn_rise = btn_sync & ~btn_prev;
  assign push     = btn_rise | repeat_push;
  assign pop      = cu_inSignal & data_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      btn_prev   <= 1'b0;
    end else begin
      btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], DB_out};
      sw_sync_q[0] <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      btn_prev     <= btn_sync;
    end
  end

`ifdef SWITCH_INPUT_PORT_AUTOREPEAT_EN
  logic [15:0] hold_cnt;

  // After the first repeat, rewind so the next hit on REPEAT_DELAY is REPEAT_RATE clocks later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (!btn_sync) begin
      hold_cnt <= '0;
    end else if (hold_cnt == REPEAT_DELAY) begin
      hold_cnt <= REPEAT_DELAY - REPEAT_RATE + 16'd1;
    end else begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  assign repeat_push = btn_sync & (hold_cnt == REPEAT_DELAY);
`else
  assign repeat_push = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push & full & ~pop) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (sw_sync_q[SYNC_STAGES-1]),
    .rdata (in_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign data_valid = ~empty;
  assign hlt_req    = cu_inSignal & ~data_valid;
endmodule

// File: tb/tb_switch_input_port.sv
// Bench for switch_input_port: directed plan steps plus random presses/reads against a queue model.
module tb_switch_input_port;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] switches = '0;
  logic          DB_out = 1'b0;
  logic          cu_inSignal = 1'b0;
  logic [DW-1:0] in_data;
  logic          data_valid;
  logic          hlt_req;
  logic          full;
  logic          overflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit en_cmp = 1'b0;

  always #5 clock = ~clock;

  switch_input_port #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clock       (clock),
    .reset       (reset),
    .switches    (switches),
    .DB_out      (DB_out),
    .cu_inSignal (cu_inSignal),
    .in_data     (in_data),
    .data_valid  (data_valid),
    .hlt_req     (hlt_req),
    .full        (full),
    .overflow    (overflow),
    .count       (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words in a queue; button/switch seen through an SS-deep delay line.
  logic [DW-1:0] mq[$];
  logic          movf = 1'b0;
  logic          m_db [SS];
  logic [DW-1:0] m_sw [SS];
  logic          m_prev = 1'b0;
  logic          m_rise;
  logic          m_pop;

  initial begin
    for (int i = 0; i < SS; i++) begin
      m_db[i] = 1'b0;
      m_sw[i] = '0;
    end
  end

  // Inputs change just after posedge, so at negedge they equal what the next posedge samples.
  always @(negedge clock) begin
    if (!reset) begin
      mq.delete();
      movf   = 1'b0;
      m_prev = 1'b0;
      for (int i = 0; i < SS; i++) begin
        m_db[i] = 1'b0;
        m_sw[i] = '0;
      end
    end else begin
      if (en_cmp) begin
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_valid", 32'(data_valid), 32'(mq.size() != 0));
        chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
        chk("m_overflow", 32'(overflow), 32'(movf));
        chk("m_hlt", 32'(hlt_req), 32'(cu_inSignal && mq.size() == 0));
        if (mq.size() != 0) chk("m_in_data", 32'(in_data), 32'(mq[0]));
      end
      m_rise = m_db[SS-1] && !m_prev;
      m_pop  = cu_inSignal && mq.size() != 0;
      if (m_pop) void'(mq.pop_front());
      if (m_rise) begin
        if (mq.size() < DEPTH) mq.push_back(m_sw[SS-1]);
        else movf = 1'b1;
      end
      m_prev = m_db[SS-1];
      for (int i = SS - 1; i > 0; i--) begin
        m_db[i] = m_db[i-1];
        m_sw[i] = m_sw[i-1];
      end
      m_db[0] = DB_out;
      m_sw[0] = switches;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [DW-1:0] v);
    switches = v;
    DB_out   = 1'b1;
    repeat (4) tick();
    DB_out   = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int hold;
    logic [DW-1:0] exp5 [4];
    reset = 1'b0;

    // 1: reset state and idle
    #23;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_hlt", 32'(hlt_req), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_in_data", 32'(in_data), 0);
    @(negedge clock);
    #1 reset = 1'b1;
    en_cmp = 1'b1;
    repeat (20) tick();
    chk("idle_count", 32'(count), 0);

    // 2: single capture, latency SS+1
    switches = 16'hA5C3;
    DB_out   = 1'b1;
    tick();
    tick();
    chk("lat2_valid", 32'(data_valid), 0);
    tick();
    chk("lat3_valid", 32'(data_valid), 1);
    chk("cap_data", 32'(in_data), 32'h0000A5C3);
    chk("cap_count", 32'(count), 1);
    repeat (97) tick();
    chk("held_count", 32'(count), 1);
    DB_out = 1'b0;
    repeat (3) tick();
    cu_inSignal = 1'b1;
    tick();
    cu_inSignal = 1'b0;
    chk("drain_count", 32'(count), 0);

    // 3: stall then resume
    cu_inSignal = 1'b1;
    #1;
    chk("stall_hlt", 32'(hlt_req), 1);
    switches = 16'h0042;
    DB_out   = 1'b1;
    n = 0;
    while (!data_valid && n < 10) begin
      tick();
      n++;
    end
    chk("stall_wait_valid", 32'(data_valid), 1);
    chk("resume_hlt", 32'(hlt_req), 0);
    chk("resume_data", 32'(in_data), 32'h00000042);
    tick();
    chk("resume_count", 32'(count), 0);
    cu_inSignal = 1'b0;
    DB_out      = 1'b0;
    repeat (3) tick();

    // 4: fill and overflow
    for (int v = 1; v <= 5; v++) press(DW'(v));
    chk("fill_count", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_overflow", 32'(overflow), 1);
    cu_inSignal = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk("fill_order", 32'(in_data), 32'(v));
      tick();
    end
    cu_inSignal = 1'b0;
    chk("fill_drained", 32'(count), 0);
    chk("fill_ovf_sticky", 32'(overflow), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // 5: full with simultaneous push and pop
    for (int v = 1; v <= 4; v++) press(DW'(v));
    switches = 16'd9;
    DB_out   = 1'b1;
    tick();
    tick();
    cu_inSignal = 1'b1;
    tick();
    cu_inSignal = 1'b0;
    chk("pp_count", 32'(count), 4);
    chk("pp_overflow", 32'(overflow), 0);
    DB_out = 1'b0;
    repeat (3) tick();
    exp5[0] = 16'd2; exp5[1] = 16'd3; exp5[2] = 16'd4; exp5[3] = 16'd9;
    cu_inSignal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", 32'(in_data), 32'(exp5[i]));
      tick();
    end
    cu_inSignal = 1'b0;

    // 6: asynchronous reset mid-operation
    for (int v = 1; v <= 3; v++) press(DW'(16'h0100 + v));
    chk("mid_count", 32'(count), 3);
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(data_valid), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_full", 32'(full), 0);
    tick();
    reset = 1'b1;
    tick();

    // Random presses and reads; read pressure low then high to hit full and empty.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        DB_out = ~DB_out;
        hold   = $urandom_range(1, 6);
      end else begin
        hold--;
      end
      switches    = DW'($urandom);
      cu_inSignal = (c < 2000) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 4);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_input_port.md
Name: switch_input_port

Overview:
Input-side responder for the CPU's IN instruction.
- Synchronizes the debounced enter button and the 16 switches into the clock domain.
- On each enter press, captures the switch word into a small FIFO.
- Serves the CPU read: presents the head word, pops it on the IN cycle, and stalls the CPU via a halt request when no word is buffered.
- Sits between deBouncer/switches and the In Signal MUX; replaces the enterFlag handshake.

Parameters:
DATA_W, 16, switch/data word width
DEPTH, 4, FIFO entries; power of two, minimum 2
SYNC_STAGES, 2, synchronizer flops on button and switches; minimum 2

Ports:
clock  input  1  system clock (wire_clock domain)
reset  input  1  asynchronous, active-low reset
switches  input  DATA_W  raw switch levels
DB_out  input  1  debounced enter button level, active-high, asynchronous to clock
cu_inSignal  input  1  CPU is executing IN this cycle (read request)
in_data  output  DATA_W  FIFO head word (show-ahead)
data_valid  output  1  FIFO not empty
hlt_req  output  1  stall request to PC: cu_inSignal & ~data_valid
full  output  1  FIFO holds DEPTH words
overflow  output  1  sticky: a capture was dropped
count  output  $clog2(DEPTH)+1  words buffered

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizers, edge detector, pointers and count cleared; overflow=0.
  - Outputs: in_data=0, data_valid=0, hlt_req=0, full=0, count=0.
  - Buffered data is discarded when reset asserts mid-operation.
- Synchronization:
  - DB_out and switches each pass SYNC_STAGES flops.
  - btn_prev holds the last synchronized button value; a rising edge is btn_sync & ~btn_prev.
- Push:
  - On a rising edge, the synchronized switch word is written at wr_ptr next clock edge.
  - Latency, DB_out rise to data_valid=1: SYNC_STAGES+1 clocks.
  - A held button gives exactly one push (unless the optional feature is enabled).
- Pop:
  - Occurs when cu_inSignal=1 and data_valid=1.
  - in_data shows the head combinationally from storage; rd_ptr advances at the clock edge.
  - The CPU samples in_data in the same cycle.
- Stall:
  - hlt_req is combinational.
  - The PC holds while it is 1; the IN instruction re-executes each cycle until a word arrives.
- Empty with push and request in the same cycle: push happens; hlt_req stays 1 that cycle; pop occurs the next cycle.
- Full:
  - Push alone: word dropped, overflow set to 1 and held until reset; count stays DEPTH.
  - Push and pop in the same cycle: both proceed; count unchanged; no overflow.
- Pointers: wrap modulo DEPTH. count is the push-minus-pop difference; full = (count==DEPTH); data_valid = (count!=0).
- in_data when empty: holds the last storage word at rd_ptr. It is not meaningful and must not be relied on.

Optional Feature:
- Macro: SWITCH_INPUT_PORT_AUTOREPEAT_EN.
- Enabled:
  - A 16-bit hold counter runs while btn_sync=1.
  - When it reaches REPEAT_DELAY (localparam 16'd50000), it emits an extra push.
  - After that, it pushes every REPEAT_RATE (16'd10000) clocks while the button is held.
  - The counter clears on release or reset.
  - Repeat pushes obey the full/overflow rules.
- Disabled: counter logic absent; one push per press only.

Decomposition:
- Package switch_input_pkg:
  - DATA_W/DEPTH defaults.
  - REPEAT_DELAY and REPEAT_RATE constants.
  - Pointer-width function ($clog2 wrapper).
- Sub-module sync_fifo:
  - Parameterized DATA_W/DEPTH.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Same clock/reset convention.
- The top keeps synchronizers, edge detect, autorepeat, hlt_req and overflow.

Test Plan:
1. Reset check: reset=0 at t=0, then release → all outputs 0; DB_out held 0 for 20 clocks → count stays 0.
2. Single capture: switches=16'hA5C3, DB_out 0→1 held 100 clocks → exactly one push; data_valid=1 at clock 3 after the rise; in_data=16'hA5C3; count=1.
3. Stall/resume: empty FIFO, cu_inSignal=1 → hlt_req=1. Press with switches=16'h0042 → data_valid rises; in the next cycle hlt_req=0, in_data=16'h0042 and the pop occurs; count returns to 0.
4. Fill/overflow: five presses with values 1..5, no reads → count=4, full=1, overflow=1. Four pops return 1,2,3,4 in order.
5. Full with simultaneous push+pop: FIFO full with 1..4; press with value 9 while cu_inSignal=1 on the push cycle → count stays 4, overflow stays 0; later pops give 2,3,4,9.
6. Reset mid-operation: count=3, assert reset for 1 clock → count=0, data_valid=0, overflow=0 immediately, without waiting for a clock edge.
